// File: rtl/bus_sequencer.sv
// Bus cycle initiator: 16-clock CPU cycle split into VIDEO (0-3), HOST (4-7) and CPU (8-15) slots.
// Video fetch is built only when BUS_VIDEO_FETCH_EN is defined; otherwise the VIDEO slot is idle.
module bus_sequencer #(
    parameter logic [16:0] VIDEO_BASE = 17'h08000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw_b,
    input  logic [10:0] video_addr,
    input  logic        host_req,
    input  logic [16:0] host_addr,
    input  logic        host_rw_b,
    output logic        host_ack,
    output logic [16:0] addr,
    output logic        rw_b,
    output logic        strobe,
    output logic        phi2,
    output logic        video_load
);

    localparam logic [3:0] SLOT_VIDEO = 4'd0;
    localparam logic [3:0] SLOT_HOST  = 4'd4;
    localparam logic [3:0] SLOT_CPU   = 4'd8;

`ifdef BUS_VIDEO_FETCH_EN
    localparam bit VIDEO_EN = 1'b1;
`else
    localparam bit VIDEO_EN = 1'b0;
    logic unused_video;
    assign unused_video = ^video_addr;
`endif

    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       host_active;

    assign cnt_nxt = cnt + 4'd1;

    // Outputs are decoded from cnt_nxt so each one is valid for the cnt value it enters with.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= 4'd0;
            addr        <= 17'd0;
            rw_b        <= 1'b1;
            strobe      <= 1'b0;
            phi2        <= 1'b0;
            video_load  <= 1'b0;
            host_ack    <= 1'b0;
            host_active <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            phi2       <= cnt_nxt[3];
            strobe     <= 1'b0;
            video_load <= 1'b0;
            host_ack   <= 1'b0;
            case (cnt_nxt)
                SLOT_VIDEO: begin
`ifdef BUS_VIDEO_FETCH_EN
                    addr <= VIDEO_BASE | {6'b0, video_addr};
`endif
                    rw_b <= 1'b1;
                end
                4'd1, 4'd2: strobe     <= VIDEO_EN;
                4'd3:       video_load <= VIDEO_EN;
                SLOT_HOST: begin
                    // The host slot is committed here; later host_req changes are ignored.
                    host_active <= host_req;
                    if (host_req) begin
                        addr <= host_addr;
                        rw_b <= host_rw_b;
                    end else begin
                        rw_b <= 1'b1;
                    end
                end
                4'd5, 4'd6: strobe   <= host_active;
                4'd7:       host_ack <= host_active;
                SLOT_CPU: begin
                    host_active <= 1'b0;
                    addr        <= {1'b0, cpu_addr};
                    rw_b        <= cpu_rw_b;
                end
                // Strobe drops at cnt 15 so write data is held past strobe and before phi2 falls.
                4'd10, 4'd11, 4'd12, 4'd13, 4'd14: strobe <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: reset, free run, CPU write, video fetch, single and held host requests.
module tb_bus_sequencer;

    localparam logic [16:0] VIDEO_BASE = 17'h08000;
`ifdef BUS_VIDEO_FETCH_EN
    localparam bit VID = 1'b1;
`else
    localparam bit VID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_rw_b;
    logic [10:0] video_addr;
    logic        host_req;
    logic [16:0] host_addr;
    logic        host_rw_b;
    logic        host_ack;
    logic [16:0] addr;
    logic        rw_b;
    logic        strobe;
    logic        phi2;
    logic        video_load;

    int       n_chk  = 0;
    int       n_fail = 0;
    int       acks   = 0;
    int       c      = 0;
    logic [16:0] vid_exp;

    bus_sequencer #(.VIDEO_BASE(VIDEO_BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_rw_b   (cpu_rw_b),
        .video_addr (video_addr),
        .host_req   (host_req),
        .host_addr  (host_addr),
        .host_rw_b  (host_rw_b),
        .host_ack   (host_ack),
        .addr       (addr),
        .rw_b       (rw_b),
        .strobe     (strobe),
        .phi2       (phi2),
        .video_load (video_load)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        c = (c + 1) % 16;
        if (host_ack === 1'b1) acks++;
    endtask

    task automatic video_slot(input logic [16:0] exp_addr);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("video addr c%0d", c), 32'(addr), 32'(exp_addr));
            chk($sformatf("video rw_b c%0d", c), 32'(rw_b), 32'd1);
            chk($sformatf("video strobe c%0d", c), 32'(strobe), 32'(VID && (c == 1 || c == 2)));
            chk($sformatf("video load c%0d", c), 32'(video_load), 32'(VID && c == 3));
            chk($sformatf("video phi2 c%0d", c), 32'(phi2), 32'd0);
            chk($sformatf("video ack c%0d", c), 32'(host_ack), 32'd0);
        end
    endtask

    task automatic host_slot(input logic active, input logic [16:0] exp_addr, input logic exp_rw);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("host addr c%0d", c), 32'(addr), 32'(exp_addr));
            chk($sformatf("host rw_b c%0d", c), 32'(rw_b), 32'(active ? exp_rw : 1'b1));
            chk($sformatf("host strobe c%0d", c), 32'(strobe), 32'(active && (c == 5 || c == 6)));
            chk($sformatf("host ack c%0d", c), 32'(host_ack), 32'(active && c == 7));
            chk($sformatf("host phi2 c%0d", c), 32'(phi2), 32'd0);
            chk($sformatf("host vload c%0d", c), 32'(video_load), 32'd0);
        end
    endtask

    task automatic cpu_slot(input logic [16:0] exp_addr, input logic exp_rw);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("cpu addr c%0d", c), 32'(addr), 32'(exp_addr));
            chk($sformatf("cpu rw_b c%0d", c), 32'(rw_b), 32'(exp_rw));
            chk($sformatf("cpu strobe c%0d", c), 32'(strobe), 32'(c >= 10 && c <= 14));
            chk($sformatf("cpu phi2 c%0d", c), 32'(phi2), 32'd1);
            chk($sformatf("cpu ack c%0d", c), 32'(host_ack), 32'd0);
            chk($sformatf("cpu vload c%0d", c), 32'(video_load), 32'd0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        cpu_addr   = 16'h1234;
        cpu_rw_b   = 1'b1;
        video_addr = 11'h000;
        host_req   = 1'b0;
        host_addr  = 17'h00000;
        host_rw_b  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset addr", 32'(addr), 32'h0);
        chk("reset rw_b", 32'(rw_b), 32'd1);
        chk("reset strobe", 32'(strobe), 32'd0);
        chk("reset phi2", 32'(phi2), 32'd0);
        chk("reset vload", 32'(video_load), 32'd0);
        chk("reset ack", 32'(host_ack), 32'd0);
        reset = 1'b0;
        c = 0;

        // Free run into the CPU slot, then reset asynchronously at cnt 9.
        repeat (8) tick();
        chk("run phi2 c8", 32'(phi2), 32'd1);
        chk("run addr c8", 32'(addr), 32'h01234);
        tick();
        chk("run phi2 c9", 32'(phi2), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async addr", 32'(addr), 32'h0);
        chk("async rw_b", 32'(rw_b), 32'd1);
        chk("async phi2", 32'(phi2), 32'd0);
        chk("async strobe", 32'(strobe), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        c = 0;

        // Seven clocks after release phi2 is still low; the eighth enters cnt 8.
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("release phi2 c%0d", c), 32'(phi2), 32'd0);
            chk($sformatf("release ack c%0d", c), 32'(host_ack), 32'd0);
        end

        // CPU write.
        cpu_addr = 16'h8123;
        cpu_rw_b = 1'b0;
        cpu_slot(17'h08123, 1'b0);

        // Video fetch (or idle video slot holding the CPU address).
        video_addr = 11'h7FF;
        cpu_rw_b   = 1'b1;
        vid_exp    = VID ? 17'h087FF : 17'h08123;
        video_slot(vid_exp);

        // Single host read; host_addr changes after the latch must not matter.
        host_req  = 1'b1;
        host_addr = 17'h1E810;
        host_rw_b = 1'b1;
        acks = 0;
        tick();
        chk("host1 addr c4", 32'(addr), 32'h1E810);
        chk("host1 rw_b c4", 32'(rw_b), 32'd1);
        host_addr = 17'h00000;
        host_rw_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("host1 addr c%0d", c), 32'(addr), 32'h1E810);
            chk($sformatf("host1 rw_b c%0d", c), 32'(rw_b), 32'd1);
            chk($sformatf("host1 strobe c%0d", c), 32'(strobe), 32'(c == 5 || c == 6));
            chk($sformatf("host1 ack c%0d", c), 32'(host_ack), 32'(c == 7));
        end
        host_req = 1'b0;
        cpu_slot(17'h08123, 1'b1);
        video_slot(vid_exp);
        host_slot(1'b0, vid_exp, 1'b1);
        cpu_slot(17'h08123, 1'b1);
        chk("host1 ack count", 32'(acks), 32'd1);

        // Held host write for three cycles.
        host_req  = 1'b1;
        host_addr = 17'h05555;
        host_rw_b = 1'b0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            video_slot(vid_exp);
            host_slot(1'b1, 17'h05555, 1'b0);
            if (i == 2) host_req = 1'b0;
            cpu_slot(17'h08123, 1'b1);
        end
        video_slot(vid_exp);
        host_slot(1'b0, vid_exp, 1'b1);
        cpu_slot(17'h08123, 1'b1);
        chk("held ack count", 32'(acks), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
